idu_pipe: RTL and testbench

IDU_PIPE -- requirements
Module: idu_pipe

---
 rtl/idu_pkg.sv | 36 +++
 rtl/idu_regusage.sv | 18 +
 rtl/idu_pipe.sv | 125 ++++++++++++
 tb/tb_idu_pipe.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/idu_pkg.sv
// idu_pkg: shared opcodes, instruction classes, usage record and parameter defaults
package idu_pkg;
    localparam int XLEN_DEF     = 32;
    localparam int NREG_DEF     = 32;
    localparam int WB_PORTS_DEF = 2;
    localparam int SB_CNT_W_DEF = 2;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {T_R, T_I, T_S, T_B, T_U, T_J, T_SYS} itype_e;

    typedef struct packed {
        logic rs1_used;
        logic rs2_used;
        logic rd_wen;
    } usage_t;

    function automatic itype_e op_type(input logic [6:0] op);
        return (op == OP_REG)                                   ? T_R :
               (op == OP_STORE)                                 ? T_S :
               (op == OP_BRANCH)                                ? T_B :
               (op == OP_LUI || op == OP_AUIPC)                 ? T_U :
               (op == OP_JAL)                                   ? T_J :
               (op == OP_SYSTEM)                                ? T_SYS :
               (op == OP_LOAD || op == OP_IMM || op == OP_JALR) ? T_I : T_I;
    endfunction
endpackage

// File: rtl/idu_regusage.sv
// idu_regusage: opcode-driven decode of source usage and destination write enable
module idu_regusage
    import idu_pkg::*;
(
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic [4:0] rd,
    output usage_t     use_o
);
    itype_e t;

    always_comb begin
        t = op_type(op);
        use_o.rs1_used = !(t == T_U || t == T_J);
        use_o.rs2_used = t == T_R || t == T_S || t == T_B;
        use_o.rd_wen   = !(t == T_S || t == T_B || (t == T_SYS && funct3 == 3'd0)) && rd != 5'd0;
    end
endmodule

// File: rtl/idu_pipe.sv
// idu_pipe: single-entry decode/issue stage with scoreboard stalls and writeback forwarding
module idu_pipe
    import idu_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREG     = NREG_DEF,
    parameter int WB_PORTS = WB_PORTS_DEF,
    parameter int SB_CNT_W = SB_CNT_W_DEF
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [XLEN-1:0]         in_inst,
    input  logic [XLEN-1:0]         in_pc,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         out_inst,
    output logic [XLEN-1:0]         out_pc,
    output logic [XLEN-1:0]         out_rs1_val,
    output logic [XLEN-1:0]         out_rs2_val,
    output logic [4:0]              out_rd,
    output logic                    out_rd_wen,
    output logic [4:0]              rf_raddr1,
    output logic [4:0]              rf_raddr2,
    input  logic [XLEN-1:0]         rf_rdata1,
    input  logic [XLEN-1:0]         rf_rdata2,
    input  logic [WB_PORTS-1:0]     wb_valid,
    input  logic [5*WB_PORTS-1:0]   wb_rd,
    input  logic [XLEN*WB_PORTS-1:0] wb_data,
    input  logic                    flush,
    output logic                    sb_err
);
    logic full_q, full_d, sb_err_q, sb_err_d;
    logic [XLEN-1:0] inst_q, inst_d, pc_q, pc_d, fwd1, fwd2;
    logic [NREG-1:0][SB_CNT_W-1:0] cnt_q, cnt_d;
    logic [SB_CNT_W-1:0] c1, c2, crd;
    logic [4:0] rs1, rs2;
    logic hit1, hit2, haz1, haz2, ovf, issue, accept, fw_ok1, fw_ok2;
    int dec, cur;
    usage_t u;

    idu_regusage u_use (
        .op     (inst_q[6:0]),
        .funct3 (inst_q[14:12]),
        .rd     (inst_q[11:7]),
        .use_o  (u)
    );

    assign rs1        = inst_q[19:15];
    assign rs2        = inst_q[24:20];
    assign rf_raddr1  = rs1;
    assign rf_raddr2  = rs2;
    assign out_inst   = inst_q;
    assign out_pc     = pc_q;
    assign out_rd     = inst_q[11:7];
    assign out_rd_wen = full_q && u.rd_wen;
    assign sb_err     = sb_err_q;

    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        fwd1 = '0;
        fwd2 = '0;
        for (int i = WB_PORTS - 1; i >= 0; i--) begin
            if (wb_valid[i] && wb_rd[5*i +: 5] == rs1) begin
                hit1 = 1'b1;
                fwd1 = wb_data[XLEN*i +: XLEN];
            end
            if (wb_valid[i] && wb_rd[5*i +: 5] == rs2) begin
                hit2 = 1'b1;
                fwd2 = wb_data[XLEN*i +: XLEN];
            end
        end
        c1 = cnt_q[rs1];
        c2 = cnt_q[rs2];
        crd = cnt_q[out_rd];
        // a lone pending write retiring this cycle can be bypassed instead of stalling
        fw_ok1 = c1 == SB_CNT_W'(1) && hit1;
        fw_ok2 = c2 == SB_CNT_W'(1) && hit2;
        haz1 = u.rs1_used && rs1 != 5'd0 && c1 != '0 && !fw_ok1;
        haz2 = u.rs2_used && rs2 != 5'd0 && c2 != '0 && !fw_ok2;
        ovf = u.rd_wen && &crd;
        out_valid = full_q && !flush && !haz1 && !haz2 && !ovf;
        issue = out_valid && out_ready;
        in_ready = !flush && (!full_q || issue);
        accept = in_valid && in_ready;
        out_rs1_val = rs1 == 5'd0 ? '0 : fw_ok1 ? fwd1 : rf_rdata1;
        out_rs2_val = rs2 == 5'd0 ? '0 : fw_ok2 ? fwd2 : rf_rdata2;
        full_d = flush ? 1'b0 : accept ? 1'b1 : issue ? 1'b0 : full_q;
        inst_d = accept ? in_inst : inst_q;
        pc_d = accept ? in_pc : pc_q;
    end

    always_comb begin
        cnt_d = cnt_q;
        sb_err_d = sb_err_q;
        dec = 0;
        cur = 0;
        for (int r = 1; r < NREG; r++) begin
            dec = 0;
            for (int p = 0; p < WB_PORTS; p++)
                dec += int'(wb_valid[p] && wb_rd[5*p +: 5] == 5'(r));
            cur = int'(cnt_q[r]);
            sb_err_d = sb_err_d || dec > cur;
            cnt_d[r] = SB_CNT_W'((dec > cur ? 0 : cur - dec) + int'(issue && out_rd_wen && out_rd == 5'(r)));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q   <= 1'b0;
            inst_q   <= '0;
            pc_q     <= '0;
            cnt_q    <= '0;
            sb_err_q <= 1'b0;
        end else begin
            full_q   <= full_d;
            inst_q   <= inst_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            sb_err_q <= sb_err_d;
        end
    end
endmodule

// File: tb/tb_idu_pipe.sv
// tb_idu_pipe: directed scenarios plus random traffic against a pending-write reference model
module tb_idu_pipe;
    localparam logic [6:0] OPI = 7'b0010011;
    localparam logic [6:0] OPR = 7'b0110011;

    logic        clk = 1'b0, rst = 1'b1;
    logic        in_valid, in_ready, out_valid, out_ready, out_rd_wen, flush, sb_err;
    logic [31:0] in_inst, in_pc, out_inst, out_pc, out_rs1_val, out_rs2_val, rf_rdata1, rf_rdata2;
    logic [4:0]  out_rd, rf_raddr1, rf_raddr2;
    logic [1:0]  wb_valid;
    logic [9:0]  wb_rd;
    logic [63:0] wb_data;

    logic [31:0] rf [32];
    logic [6:0]  ops [10] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                              7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1110011};

    bit          m_full, m_err;
    logic [31:0] m_inst, m_pc;
    int          pend [32];
    int          checks = 0, errors = 0;
    logic        s_ov, s_ir, s_err;
    logic [31:0] s_r1, s_r2;
    logic [7:0]  iss_pat, ir_pat;

    always #5 clk = ~clk;

    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];

    idu_pipe dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
        .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_rd(out_rd), .out_rd_wen(out_rd_wen),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush), .sb_err(sb_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] usage(input logic [31:0] ins);
        logic r1, r2, w;
        r1 = 1'b1;
        r2 = 1'b0;
        w = 1'b1;
        case (ins[6:0])
            7'b0110111, 7'b0010111, 7'b1101111: r1 = 1'b0;
            7'b0110011: r2 = 1'b1;
            7'b0100011, 7'b1100011: begin r2 = 1'b1; w = 1'b0; end
            7'b1110011: w = ins[14:12] != 3'd0;
            default: ;
        endcase
        return {r1, r2, w && ins[11:7] != 5'd0};
    endfunction

    function automatic logic [31:0] mk(input logic [6:0] op, input int rd, input int rs1, input int rs2, input int f3);
        return {7'd0, 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), op};
    endfunction

    task automatic idle();
        in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b1;
        wb_valid = '0; wb_rd = '0; wb_data = '0; flush = 1'b0;
    endtask

    task automatic wbset(input int p, input int rd, input logic [31:0] d);
        wb_valid[p] = 1'b1;
        wb_rd[5*p +: 5] = 5'(rd);
        wb_data[32*p +: 32] = d;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        m_full = 0; m_err = 0; m_inst = '0; m_pc = '0;
        foreach (pend[i]) pend[i] = 0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_sb_err", 32'(sb_err), 32'd0);
        chk("rst_out_inst", out_inst, 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_rd", 32'(out_rd), 32'd0);
        chk("rst_out_rd_wen", 32'(out_rd_wen), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // one clock: check DUT against model at the negedge, advance model, return 1 after posedge
    task automatic step();
        logic [2:0] u;
        bit hit1, hit2, stall, ov, ir, issue, acc;
        logic [31:0] d1, d2, e1, e2;
        int s1, s2, rd, r;
        @(negedge clk);
        u = usage(m_inst);
        s1 = int'(m_inst[19:15]);
        s2 = int'(m_inst[24:20]);
        rd = int'(m_inst[11:7]);
        hit1 = 0; hit2 = 0; d1 = '0; d2 = '0;
        for (int p = 0; p < 2; p++) begin
            if (!hit1 && wb_valid[p] && int'(wb_rd[5*p +: 5]) == s1) begin hit1 = 1; d1 = wb_data[32*p +: 32]; end
            if (!hit2 && wb_valid[p] && int'(wb_rd[5*p +: 5]) == s2) begin hit2 = 1; d2 = wb_data[32*p +: 32]; end
        end
        stall = (u[2] && s1 != 0 && pend[s1] > 0 && !(pend[s1] == 1 && hit1)) ||
                (u[1] && s2 != 0 && pend[s2] > 0 && !(pend[s2] == 1 && hit2)) ||
                (u[0] && pend[rd] == 3);
        ov = m_full && !flush && !stall;
        ir = !flush && (!m_full || (ov && out_ready));
        e1 = s1 == 0 ? 32'd0 : (pend[s1] == 1 && hit1) ? d1 : rf[s1];
        e2 = s2 == 0 ? 32'd0 : (pend[s2] == 1 && hit2) ? d2 : rf[s2];
        chk("out_valid", 32'(out_valid), 32'(ov));
        chk("in_ready", 32'(in_ready), 32'(ir));
        chk("sb_err", 32'(sb_err), 32'(m_err));
        if (m_full) begin
            chk("out_inst", out_inst, m_inst);
            chk("out_pc", out_pc, m_pc);
            chk("out_rd", 32'(out_rd), 32'(rd));
            chk("out_rd_wen", 32'(out_rd_wen), 32'(u[0]));
        end
        if (ov) begin
            chk("rs1_val", out_rs1_val, e1);
            chk("rs2_val", out_rs2_val, e2);
        end
        s_ov = out_valid; s_ir = in_ready; s_err = sb_err; s_r1 = out_rs1_val; s_r2 = out_rs2_val;
        issue = ov && out_ready;
        acc = in_valid && ir;
        for (int p = 0; p < 2; p++) begin
            r = int'(wb_rd[5*p +: 5]);
            if (wb_valid[p] && r != 0) begin
                if (pend[r] > 0) pend[r]--;
                else m_err = 1;
            end
        end
        if (issue && u[0]) pend[rd]++;
        m_full = flush ? 0 : acc ? 1 : issue ? 0 : m_full;
        if (acc) begin m_inst = in_inst; m_pc = in_pc; end
        iss_pat = {iss_pat[6:0], issue};
        ir_pat = {ir_pat[6:0], ir};
        @(posedge clk);
        #1;
        for (int p = 1; p >= 0; p--)
            if (wb_valid[p]) rf[wb_rd[5*p +: 5]] = wb_data[32*p +: 32];
    endtask

    task automatic rand_inputs();
        int r, need;
        in_valid = $urandom_range(0, 3) != 0;
        in_inst = mk(ops[$urandom_range(0, 9)], $urandom_range(0, 7), $urandom_range(0, 7),
                     $urandom_range(0, 7), $urandom_range(0, 7));
        in_pc = $urandom;
        out_ready = $urandom_range(0, 3) != 0;
        flush = $urandom_range(0, 29) == 0;
        for (int p = 0; p < 2; p++) begin
            wb_valid[p] = 1'b0;
            wb_rd[5*p +: 5] = '0;
            wb_data[32*p +: 32] = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                r = $urandom_range(1, 7);
                need = (p == 1 && wb_valid[0] && int'(wb_rd[4:0]) == r) ? 2 : 1;
                if (pend[r] >= need) begin
                    wb_valid[p] = 1'b1;
                    wb_rd[5*p +: 5] = 5'(r);
                end
            end
        end
        if (!wb_valid[1] && $urandom_range(0, 15) == 0) wb_valid[1] = 1'b1;
    endtask

    initial begin
        foreach (rf[i]) rf[i] = $urandom;
        rf[0] = 32'hDEAD_BEEF;
        iss_pat = '0; ir_pat = '0;
        do_reset();

        // back-to-back independent addi x1..x4
        for (int k = 1; k <= 4; k++) begin
            in_valid = 1'b1; in_inst = mk(OPI, k, 0, 0, 0); in_pc = 32'(4 * k);
            step();
        end
        idle();
        step();
        chk("b2b_issue_pattern", 32'(iss_pat[4:0]), 32'b01111);
        chk("b2b_in_ready_pattern", 32'(ir_pat[4:0]), 32'b11111);
        wbset(0, 1, 32'h11); wbset(1, 2, 32'h22); step();
        wbset(0, 3, 32'h33); wbset(1, 4, 32'h44); step();
        idle();

        // RAW hazard resolved by forwarding on port 1
        in_valid = 1'b1; in_inst = mk(OPR, 5, 1, 2, 0); in_pc = 32'h100; step();
        in_inst = mk(OPR, 6, 5, 5, 0); in_pc = 32'h104; step();
        in_valid = 1'b0; step();
        chk("raw_stall", 32'(s_ov), 32'd0);
        wbset(1, 5, 32'h1234); step();
        chk("raw_fwd_valid", 32'(s_ov), 32'd1);
        chk("raw_fwd_rs1", s_r1, 32'h1234);
        chk("raw_fwd_rs2", s_r2, 32'h1234);
        idle();

        // both ports write x7: lowest port wins
        in_valid = 1'b1; in_inst = mk(OPI, 7, 0, 0, 0); in_pc = 32'h200; step();
        in_inst = mk(OPR, 8, 7, 7, 0); in_pc = 32'h204; step();
        in_valid = 1'b0; step();
        wbset(0, 7, 32'hA); wbset(1, 7, 32'hB); step();
        chk("dual_fwd_valid", 32'(s_ov), 32'd1);
        chk("dual_fwd_rs1", s_r1, 32'hA);
        chk("dual_fwd_rs2", s_r2, 32'hA);
        idle();
        step();

        // asynchronous reset while holding an instruction
        in_valid = 1'b1; in_inst = mk(OPI, 10, 0, 0, 0); in_pc = 32'h300; step();
        in_valid = 1'b0;
        rst = 1'b1;
        #1 chk("async_rst_valid", 32'(out_valid), 32'd0);
        do_reset();

        // scoreboard saturation on x3
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_inst = mk(OPI, 3, 0, 0, 0); in_pc = 32'(32'h400 + 4 * k);
            step();
        end
        idle();
        step();
        chk("ovf_stall_a", 32'(s_ov), 32'd0);
        step();
        chk("ovf_stall_b", 32'(s_ov), 32'd0);
        wbset(0, 3, 32'h3); step();
        chk("ovf_stall_wb_cycle", 32'(s_ov), 32'd0);
        idle();
        step();
        chk("ovf_issue", 32'(s_ov), 32'd1);
        wbset(0, 3, 32'h31); wbset(1, 3, 32'h32); step();
        idle(); wbset(0, 3, 32'h33); step();
        idle();

        // underflow on x9 sets a sticky error
        wbset(0, 9, 32'h9); step();
        chk("err_pre", 32'(s_err), 32'd0);
        idle();
        step();
        chk("err_set", 32'(s_err), 32'd1);
        repeat (3) step();
        chk("err_hold", 32'(s_err), 32'd1);

        // flush a stalled consumer; its producer's pending write survives
        in_valid = 1'b1; in_inst = mk(OPI, 11, 0, 0, 0); in_pc = 32'h500; step();
        in_inst = mk(OPR, 12, 11, 11, 0); in_pc = 32'h504; step();
        in_valid = 1'b0; step();
        flush = 1'b1; in_valid = 1'b1; in_inst = mk(OPI, 13, 0, 0, 0); in_pc = 32'h508; step();
        chk("flush_in_ready", 32'(s_ir), 32'd0);
        chk("flush_out_valid", 32'(s_ov), 32'd0);
        flush = 1'b0; in_valid = 1'b0; step();
        chk("post_flush_valid", 32'(s_ov), 32'd0);
        in_valid = 1'b1; in_inst = mk(OPR, 14, 11, 0, 0); in_pc = 32'h50C; step();
        in_valid = 1'b0; step();
        chk("pend_kept_stall", 32'(s_ov), 32'd0);
        wbset(0, 11, 32'h77); step();
        chk("pend_kept_fwd_valid", 32'(s_ov), 32'd1);
        chk("pend_kept_fwd_rs1", s_r1, 32'h77);
        idle();
        step();
        do_reset();
        step();
        chk("err_cleared", 32'(s_err), 32'd0);

        // random traffic
        for (int c = 0; c < 800; c++) begin
            rand_inputs();
            step();
        end
        idle();
        repeat (2) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
